// File: rtl/zet_rep_pkg.sv
// Shared definitions for the string-instruction repeat controller.
// Holds the controller state enum, the seven string opcodes (as opcode[7:1],
// so both byte and word forms map to the same value), the prefix bit
// positions and a helper that recognises a string opcode.
package zet_rep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH
    } state_t;

    // opcode[7:1] of the string instructions
    localparam logic [6:0] OP_MOVS = 7'h52;  // A4/A5
    localparam logic [6:0] OP_CMPS = 7'h53;  // A6/A7
    localparam logic [6:0] OP_STOS = 7'h55;  // AA/AB
    localparam logic [6:0] OP_LODS = 7'h56;  // AC/AD
    localparam logic [6:0] OP_SCAS = 7'h57;  // AE/AF
    localparam logic [6:0] OP_INS  = 7'h36;  // 6C/6D
    localparam logic [6:0] OP_OUTS = 7'h37;  // 6E/6F

    // prefix bit positions
    localparam int PREFIX_REP_BIT = 1;  // REP prefix present
    localparam int PREFIX_Z_BIT   = 0;  // 1 = repz/rep, 0 = repnz

    function automatic logic is_string_op(input logic [6:0] op);
        return op inside {OP_MOVS, OP_CMPS, OP_STOS, OP_LODS,
                          OP_SCAS, OP_INS, OP_OUTS};
    endfunction

endpackage

// File: rtl/zet_rep_ctrl_if.sv
// Bus between the instruction decoder / string execution unit and the
// repeat controller.
//   master: decoder/exec side, drives start, prefix, opcode, cx_in, zf,
//           ext_int, iter_done; receives the controller outputs.
//   slave : repeat controller, drives busy, iter_go, cx_out, cx_we, done,
//           done_int.
interface zet_rep_ctrl_if;

    logic        start;
    logic [1:0]  prefix;
    logic [6:0]  opcode;
    logic [15:0] cx_in;
    logic        zf;
    logic        ext_int;
    logic        iter_done;

    logic        busy;
    logic        iter_go;
    logic [15:0] cx_out;
    logic        cx_we;
    logic        done;
    logic        done_int;

    modport master (
        output start, prefix, opcode, cx_in, zf, ext_int, iter_done,
        input  busy, iter_go, cx_out, cx_we, done, done_int
    );

    modport slave (
        input  start, prefix, opcode, cx_in, zf, ext_int, iter_done,
        output busy, iter_go, cx_out, cx_we, done, done_int
    );

endinterface

// File: rtl/zet_rep_decode.sv
// Combinational decode of the latched prefix/opcode.
//   prefix     : latched REP prefix bits
//   opcode     : latched opcode[7:1]
//   rep_mode   : REP prefix on a string instruction -> iterate on CX
//   compare_op : cmps/scas, which may exit early on ZF
//   repz       : repz/rep (1) versus repnz (0)
import zet_rep_pkg::*;

module zet_rep_decode (
    input  logic [1:0] prefix,
    input  logic [6:0] opcode,
    output logic       rep_mode,
    output logic       compare_op,
    output logic       repz
);

    logic string_op;

    assign string_op  = is_string_op(opcode);
    assign rep_mode   = prefix[PREFIX_REP_BIT] & string_op;
    // opcode[7] & opcode[2] & opcode[1] of the full byte singles out cmps/scas
    assign compare_op = string_op & opcode[6] & opcode[1] & opcode[0];
    assign repz       = prefix[PREFIX_Z_BIT];

endmodule

// File: rtl/zet_rep_ctrl.sv
// Repeat-prefix controller for string instructions.
// Sequences one element at a time through the execution unit, decrements CX
// in repeat mode, handles the repz/repnz early exit on compare ops and
// breaks out for pending interrupts between elements.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of zet_rep_ctrl_if (start/prefix/opcode/cx_in in,
//              iter_go/iter_done element handshake, cx_out/cx_we CX
//              writeback, done/done_int retire)
import zet_rep_pkg::*;

module zet_rep_ctrl (
    input  logic          clk,
    input  logic          rst,
    zet_rep_ctrl_if.slave bus
);

    state_t      state;
    state_t      state_next;
    logic [1:0]  prefix_q;
    logic [6:0]  opcode_q;
    logic [15:0] cx_q;
    logic        cx_we_q;
    logic        done_int_q;
    logic        done_int_next;
    logic        dec_en;
    logic        rep_mode;
    logic        compare_op;
    logic        repz;
    logic        cmp_exit;

    zet_rep_decode u_decode (
        .prefix     (prefix_q),
        .opcode     (opcode_q),
        .rep_mode   (rep_mode),
        .compare_op (compare_op),
        .repz       (repz)
    );

    // repz stops on ZF=0, repnz stops on ZF=1
    assign cmp_exit = compare_op & (repz ? ~bus.zf : bus.zf);

    always_comb begin
        state_next    = state;
        done_int_next = done_int_q;
        dec_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next    = ST_CHECK;
                    done_int_next = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!rep_mode) begin
                    state_next = ST_ISSUE;
                end else if (cx_q == 16'd0) begin
                    state_next    = ST_FINISH;
                    done_int_next = 1'b0;
                end else if (bus.ext_int) begin
                    state_next    = ST_FINISH;
                    done_int_next = 1'b1;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // ext_int is deliberately not looked at here; an element in
                // flight always completes and the interrupt is taken in CHECK
                if (bus.iter_done) begin
                    if (!rep_mode) begin
                        state_next = ST_FINISH;
                    end else begin
                        dec_en = (cx_q != 16'd0);
                        if (cmp_exit) begin
                            state_next    = ST_FINISH;
                            done_int_next = 1'b0;
                        end else begin
                            state_next = ST_CHECK;
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prefix_q   <= 2'b00;
            opcode_q   <= 7'd0;
            cx_q       <= 16'd0;
            cx_we_q    <= 1'b0;
            done_int_q <= 1'b0;
        end else begin
            state      <= state_next;
            done_int_q <= done_int_next;
            cx_we_q    <= dec_en;
            if (state == ST_IDLE && bus.start) begin
                prefix_q <= bus.prefix;
                opcode_q <= bus.opcode;
                cx_q     <= bus.cx_in;
            end else if (dec_en) begin
                cx_q <= cx_q - 16'd1;
            end
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.iter_go  = (state == ST_ISSUE);
    assign bus.done     = (state == ST_FINISH);
    assign bus.done_int = (state == ST_FINISH) & done_int_q;
    assign bus.cx_out   = cx_q;
    assign bus.cx_we    = cx_we_q;

endmodule
